ph_fifo_bank: RTL and testbench

PH_FIFO_BANK -- requirements
Module: ph_fifo_bank

---
 rtl/ph_fifo_pkg.sv | 10 +
 rtl/ph_fifo_if.sv | 26 ++
 rtl/ph_fifo_chan.sv | 42 ++++
 rtl/ph_fifo_bank.sv | 44 ++++
 tb/tb_ph_fifo_bank.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/ph_fifo_pkg.sv
// ph_fifo_pkg: shared defaults and count-width helper for the parasite/host FIFO bank
package ph_fifo_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_NCH = 4;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_MODE_CH = 2;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/ph_fifo_if.sv
// ph_fifo_if: parasite write side, host read side and status flags of the FIFO bank
interface ph_fifo_if #(
  parameter int WIDTH = 8,
  parameter int NCH = 4
);
  logic [WIDTH-1:0] p_data;
  logic [NCH-1:0] p_sel;
  logic p_we;
  logic [NCH-1:0] h_sel;
  logic h_rd;
  logic one_byte_mode;
  logic [NCH-1:0] ovf_clr;
  logic [WIDTH-1:0] h_data;
  logic [NCH-1:0] h_data_available;
  logic [NCH-1:0] p_full;
  logic [NCH-1:0] ovf;
  logic ph_zero_mode_bytes_avail;
  modport master (
    output p_data, p_sel, p_we, h_sel, h_rd, one_byte_mode, ovf_clr,
    input h_data, h_data_available, p_full, ovf, ph_zero_mode_bytes_avail
  );
  modport slave (
    input p_data, p_sel, p_we, h_sel, h_rd, one_byte_mode, ovf_clr,
    output h_data, h_data_available, p_full, ovf, ph_zero_mode_bytes_avail
  );
endinterface

// File: rtl/ph_fifo_chan.sv
// ph_fifo_chan: one FIFO channel; full is taken from registered count so a same-cycle pop never frees space
module ph_fifo_chan import ph_fifo_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic h_phi2,
  input  logic h_rst_b,
  input  logic wr,
  input  logic rd,
  input  logic mode_en,
  input  logic one_byte_mode,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic full,
  output logic avail,
  output logic drop
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic push, pop;
  assign avail = cnt != '0;
  assign full = cnt == CW'(DEPTH) || (mode_en && one_byte_mode && avail);
  assign push = wr && !full;
  assign pop = rd && avail;
  assign drop = wr && full;
  assign head = mem[rp];
  always_ff @(posedge h_phi2 or negedge h_rst_b)
    if (!h_rst_b) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  always_ff @(posedge h_phi2)
    if (push) mem[wp] <= din;
endmodule

// File: rtl/ph_fifo_bank.sv
// ph_fifo_bank: NCH independent FIFO channels with host read mux and sticky overflow flags
module ph_fifo_bank import ph_fifo_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NCH = DEF_NCH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int MODE_CH = DEF_MODE_CH
) (
  input logic h_phi2,
  input logic h_rst_b,
  ph_fifo_if.slave bus
);
  logic [WIDTH-1:0] head [NCH];
  logic [NCH-1:0] full, avail, drop, ovf;
  logic [WIDTH-1:0] h_data;
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    ph_fifo_chan #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_chan (
      .h_phi2(h_phi2),
      .h_rst_b(h_rst_b),
      .wr(bus.p_we && bus.p_sel[g]),
      .rd(bus.h_rd && bus.h_sel[g]),
      .mode_en(g == MODE_CH),
      .one_byte_mode(bus.one_byte_mode),
      .din(bus.p_data),
      .head(head[g]),
      .full(full[g]),
      .avail(avail[g]),
      .drop(drop[g])
    );
  end
  // descending scan so the lowest selected channel wins
  always_comb begin
    h_data = '0;
    for (int i = NCH - 1; i >= 0; i--)
      if (bus.h_sel[i]) h_data = avail[i] ? head[i] : '0;
  end
  always_ff @(posedge h_phi2 or negedge h_rst_b)
    if (!h_rst_b) ovf <= '0;
    else ovf <= (ovf & ~bus.ovf_clr) | drop;
  assign bus.h_data = h_data;
  assign bus.h_data_available = avail;
  assign bus.p_full = full;
  assign bus.ovf = ovf;
  assign bus.ph_zero_mode_bytes_avail = !avail[MODE_CH];
endmodule

// File: tb/tb_ph_fifo_bank.sv
// tb_ph_fifo_bank: directed vectors with hand-computed expectations for ph_fifo_bank
module tb_ph_fifo_bank;
  logic h_phi2 = 1'b0;
  logic h_rst_b = 1'b0;
  int vectors = 0;
  int errors = 0;
  ph_fifo_if #(.WIDTH(8), .NCH(4)) bus ();
  ph_fifo_bank #(.WIDTH(8), .NCH(4), .DEPTH(4), .MODE_CH(2)) dut (
    .h_phi2(h_phi2),
    .h_rst_b(h_rst_b),
    .bus(bus)
  );
  always #5 h_phi2 = ~h_phi2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge h_phi2);
    #1;
  endtask

  task automatic push(input int ch, input logic [7:0] d);
    bus.p_sel = 4'(1 << ch);
    bus.p_data = d;
    bus.p_we = 1'b1;
    tick();
    bus.p_we = 1'b0;
    bus.p_sel = '0;
  endtask

  task automatic pop(input string tag, input int ch, input logic [7:0] exp);
    bus.h_sel = 4'(1 << ch);
    bus.h_rd = 1'b1;
    #1 chk(tag, bus.h_data, exp);
    tick();
    bus.h_rd = 1'b0;
    bus.h_sel = '0;
  endtask

  initial begin
    bus.p_data = '0;
    bus.p_sel = '0;
    bus.p_we = 1'b0;
    bus.h_sel = '0;
    bus.h_rd = 1'b0;
    bus.one_byte_mode = 1'b0;
    bus.ovf_clr = '0;
    #1;
    chk("rst_avail", bus.h_data_available, 0);
    chk("rst_full", bus.p_full, 0);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst_zero", bus.ph_zero_mode_bytes_avail, 1);
    #11 h_rst_b = 1'b1;
    tick();
    push(0, 8'h11);
    push(0, 8'h22);
    push(0, 8'h33);
    chk("ch0_not_full3", bus.p_full[0], 0);
    push(0, 8'h44);
    chk("ch0_full4", bus.p_full[0], 1);
    chk("ch0_avail", bus.h_data_available, 4'b0001);
    pop("ch0_rd0", 0, 8'h11);
    pop("ch0_rd1", 0, 8'h22);
    pop("ch0_rd2", 0, 8'h33);
    pop("ch0_rd3", 0, 8'h44);
    chk("ch0_empty", bus.h_data_available[0], 0);
    chk("ch0_full_clr", bus.p_full[0], 0);
    for (int k = 0; k < 4; k++) push(1, 8'(8'ha1 + k));
    chk("ch1_full", bus.p_full[1], 1);
    push(1, 8'h55);
    chk("ch1_ovf", bus.ovf, 4'b0010);
    bus.ovf_clr = 4'b0010;
    tick();
    bus.ovf_clr = '0;
    chk("ch1_ovf_clr", bus.ovf, 0);
    // write plus pop on a full channel: the pop completes, the write is still dropped
    bus.p_sel = 4'b0010;
    bus.p_data = 8'h56;
    bus.p_we = 1'b1;
    bus.h_sel = 4'b0010;
    bus.h_rd = 1'b1;
    #1 chk("ch1_rd0", bus.h_data, 8'ha1);
    tick();
    bus.p_we = 1'b0;
    bus.h_rd = 1'b0;
    bus.p_sel = '0;
    bus.h_sel = '0;
    chk("ch1_ovf_pop", bus.ovf, 4'b0010);
    pop("ch1_rd1", 1, 8'ha2);
    pop("ch1_rd2", 1, 8'ha3);
    pop("ch1_rd3", 1, 8'ha4);
    chk("ch1_empty", bus.h_data_available, 0);
    bus.ovf_clr = 4'b0010;
    tick();
    bus.ovf_clr = '0;
    chk("ch1_ovf_clr2", bus.ovf, 0);
    push(3, 8'h01);
    push(3, 8'h02);
    for (int k = 0; k < 8; k++) begin
      bus.p_sel = 4'b1000;
      bus.p_data = 8'(8'h60 + k);
      bus.p_we = 1'b1;
      bus.h_sel = 4'b1000;
      bus.h_rd = 1'b1;
      #1 chk($sformatf("ch3_pp%0d", k), bus.h_data, k == 0 ? 8'h01 : k == 1 ? 8'h02 : 8'(8'h60 + k - 2));
      tick();
    end
    bus.p_we = 1'b0;
    bus.h_rd = 1'b0;
    bus.p_sel = '0;
    bus.h_sel = '0;
    chk("ch3_ovf_none", bus.ovf, 0);
    push(3, 8'h70);
    chk("ch3_cnt3", bus.p_full[3], 0);
    push(3, 8'h71);
    chk("ch3_cnt4", bus.p_full[3], 1);
    pop("ch3_rd0", 3, 8'h66);
    pop("ch3_rd1", 3, 8'h67);
    pop("ch3_rd2", 3, 8'h70);
    pop("ch3_rd3", 3, 8'h71);
    chk("ch3_empty", bus.h_data_available[3], 0);
    bus.one_byte_mode = 1'b1;
    #1 chk("obm_zero_idle", bus.ph_zero_mode_bytes_avail, 1);
    chk("obm_full_idle", bus.p_full[2], 0);
    push(2, 8'ha5);
    chk("obm_full", bus.p_full[2], 1);
    chk("obm_zero_busy", bus.ph_zero_mode_bytes_avail, 0);
    push(2, 8'h5a);
    chk("obm_ovf", bus.ovf, 4'b0100);
    bus.ovf_clr = 4'b0100;
    push(2, 8'h5b);
    bus.ovf_clr = '0;
    chk("obm_ovf_prio", bus.ovf, 4'b0100);
    bus.ovf_clr = 4'b0100;
    tick();
    bus.ovf_clr = '0;
    chk("obm_ovf_clr", bus.ovf, 0);
    pop("obm_rd", 2, 8'ha5);
    chk("obm_zero_back", bus.ph_zero_mode_bytes_avail, 1);
    bus.one_byte_mode = 1'b0;
    push(2, 8'hb1);
    push(2, 8'hb2);
    chk("obm_off_full", bus.p_full[2], 0);
    bus.one_byte_mode = 1'b1;
    #1 chk("obm_on_full2", bus.p_full[2], 1);
    pop("obm_keep0", 2, 8'hb1);
    chk("obm_on_full1", bus.p_full[2], 1);
    pop("obm_keep1", 2, 8'hb2);
    chk("obm_on_full0", bus.p_full[2], 0);
    bus.one_byte_mode = 1'b0;
    push(1, 8'hc1);
    push(2, 8'hc2);
    bus.h_sel = 4'b0110;
    #1 chk("mux_0110", bus.h_data, 8'hc1);
    bus.h_sel = 4'b0100;
    #1 chk("mux_0100", bus.h_data, 8'hc2);
    bus.h_sel = 4'b0001;
    #1 chk("mux_empty", bus.h_data, 0);
    bus.h_sel = 4'b0000;
    #1 chk("mux_none", bus.h_data, 0);
    bus.one_byte_mode = 1'b1;
    push(2, 8'hc3);
    chk("pre_rst_ovf", bus.ovf, 4'b0100);
    chk("pre_rst_avail", bus.h_data_available, 4'b0110);
    #2 h_rst_b = 1'b0;
    #1;
    chk("mid_rst_avail", bus.h_data_available, 0);
    chk("mid_rst_full", bus.p_full, 0);
    chk("mid_rst_ovf", bus.ovf, 0);
    chk("mid_rst_zero", bus.ph_zero_mode_bytes_avail, 1);
    bus.one_byte_mode = 1'b0;
    tick();
    h_rst_b = 1'b1;
    tick();
    chk("post_rst_avail", bus.h_data_available, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
